bank_burst_sequencer: RTL and testbench

Single-command burst sequencer sitting between the memory-controller front end and the `Chip` bank array. Accepts one read or write command (bank group, bank, row, start column) per handshake, then drives the selected bank's per-bank `rd_o_wr`/`row`/`column`/`dqin` signals through activate, burst and precharge phases. All other banks are held idle. Read data from the selected bank's `dqout` is returned as one beat per cycle.

---
 rtl/bank_burst_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_bank_burst_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_burst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bank_burst_sequencer                                                       |
// | Single-command activate/burst/precharge sequencer for the Chip bank array. |
// | Optional feature: BURST_CHOP_EN (adds cmd_bc4, BL/2 chopped bursts).       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bank_burst_sequencer #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int CHWIDTH      = 5,
    parameter int BL           = 8,
    parameter int TRCD         = 2,
    parameter int TRP          = 2,
    parameter int CHIP_RL      = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_wr,
    input  logic [BGWIDTH-1:0]        cmd_bg,
    input  logic [BAWIDTH-1:0]        cmd_ba,
    input  logic [CHWIDTH-1:0]        cmd_row,
    input  logic [COLWIDTH-1:0]       cmd_col,
`ifdef BURST_CHOP_EN
    input  logic                      cmd_bc4,
`endif
    output logic                      wdata_req,
    input  logic [DEVICE_WIDTH-1:0]   wdata,
    output logic                      rdata_valid,
    output logic [DEVICE_WIDTH-1:0]   rdata,
    output logic                      busy,
    output logic [(1<<BGWIDTH)-1:0][(1<<BAWIDTH)-1:0]                   chip_rd_o_wr,
    output logic [(1<<BGWIDTH)-1:0][(1<<BAWIDTH)-1:0][DEVICE_WIDTH-1:0] chip_dqin,
    input  logic [(1<<BGWIDTH)-1:0][(1<<BAWIDTH)-1:0][DEVICE_WIDTH-1:0] chip_dqout,
    output logic [(1<<BGWIDTH)-1:0][(1<<BAWIDTH)-1:0][CHWIDTH-1:0]      chip_row,
    output logic [(1<<BGWIDTH)-1:0][(1<<BAWIDTH)-1:0][COLWIDTH-1:0]     chip_column
);

    localparam int c_log2_bl = $clog2(BL);
    localparam int c_cnt_w   = $clog2(((TRCD > TRP) ? TRCD : TRP) + 1);
    localparam int c_tok_w   = 1 + BGWIDTH + BAWIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACT   = 2'd1,
        S_BURST = 2'd2,
        S_PRE   = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
    logic [c_log2_bl-1:0]   r_beat, w_beat_nxt;

    logic                   r_wr;
    logic                   r_bc4;
    logic [BGWIDTH-1:0]     r_bg;
    logic [BAWIDTH-1:0]     r_ba;
    logic [CHWIDTH-1:0]     r_row;
    logic [COLWIDTH-1:0]    r_col;

    logic                   w_accept;
    logic [c_log2_bl-1:0]   w_last_beat;
    logic [COLWIDTH-1:0]    w_mask;
    logic [COLWIDTH-1:0]    w_col_sum;
    logic [COLWIDTH-1:0]    w_col;
    logic                   w_push;
    logic [c_tok_w-1:0]     w_tok_in;
    logic [c_tok_w-1:0]     w_tok_out;
    logic                   w_tok_valid;
    logic [BGWIDTH-1:0]     w_tok_bg;
    logic [BAWIDTH-1:0]     w_tok_ba;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign w_accept  = cmd_valid & cmd_ready;

    assign w_last_beat = r_bc4 ? c_log2_bl'(BL/2 - 1) : c_log2_bl'(BL - 1);

    // Column offset wraps inside the N-aligned block; the upper bits stay fixed.
    assign w_mask    = COLWIDTH'(w_last_beat);
    assign w_col_sum = r_col + COLWIDTH'(r_beat);
    assign w_col     = (r_col & ~w_mask) | (w_col_sum & w_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = S_ACT;
                    w_cnt_nxt   = c_cnt_w'(TRCD - 1);
                    w_beat_nxt  = '0;
                end
            end
            S_ACT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_BURST;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_BURST: begin
                if (r_beat == w_last_beat) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = c_cnt_w'(TRP - 1);
                end else begin
                    w_beat_nxt = r_beat + 1'b1;
                end
            end
            S_PRE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= 1'b0;
            r_bc4 <= 1'b0;
            r_bg  <= '0;
            r_ba  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_wr  <= cmd_wr;
`ifdef BURST_CHOP_EN
            r_bc4 <= cmd_bc4;
`else
            r_bc4 <= 1'b0;
`endif
            r_bg  <= cmd_bg;
            r_ba  <= cmd_ba;
            r_row <= cmd_row;
            r_col <= cmd_col;
        end
    end

    // Only the latched bank is ever driven; every other bank sees all zeros.
    always_comb begin
        chip_rd_o_wr = '0;
        chip_dqin    = '0;
        chip_row     = '0;
        chip_column  = '0;
        wdata_req    = 1'b0;
        w_push       = 1'b0;
        if (r_state == S_ACT) begin
            chip_row[r_bg][r_ba] = r_row;
        end else if (r_state == S_BURST) begin
            chip_row[r_bg][r_ba]    = r_row;
            chip_column[r_bg][r_ba] = w_col;
            if (r_wr) begin
                chip_rd_o_wr[r_bg][r_ba] = 1'b1;
                chip_dqin[r_bg][r_ba]    = wdata;
                wdata_req                = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end
    end

    assign w_tok_in = {w_push, r_bg, r_ba};

    generate
        if (CHIP_RL == 0) begin : g_rl_zero
            assign w_tok_out = w_tok_in;
        end else begin : g_rl_pipe
            logic [c_tok_w-1:0] r_dl [CHIP_RL];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < CHIP_RL; i++) r_dl[i] <= '0;
                end else begin
                    r_dl[0] <= w_tok_in;
                    for (int i = 1; i < CHIP_RL; i++) r_dl[i] <= r_dl[i-1];
                end
            end
            assign w_tok_out = r_dl[CHIP_RL-1];
        end
    endgenerate

    assign w_tok_valid = w_tok_out[c_tok_w-1];
    assign w_tok_bg    = w_tok_out[BAWIDTH +: BGWIDTH];
    assign w_tok_ba    = w_tok_out[0 +: BAWIDTH];

    assign rdata_valid = w_tok_valid;
    assign rdata       = w_tok_valid ? chip_dqout[w_tok_bg][w_tok_ba] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bank_burst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bank_burst_sequencer                                                    |
// | Randomized bench with a cycle-offset reference model and a Chip model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bank_burst_sequencer;

    localparam int BGW  = 2;
    localparam int BAW  = 2;
    localparam int COLW = 10;
    localparam int DW   = 4;
    localparam int CHW  = 5;
    localparam int BL   = 8;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int RL   = 1;
    localparam int NBG  = 1 << BGW;
    localparam int NBA  = 1 << BAW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_wr;
    logic [BGW-1:0]       cmd_bg;
    logic [BAW-1:0]       cmd_ba;
    logic [CHW-1:0]       cmd_row;
    logic [COLW-1:0]      cmd_col;
`ifdef BURST_CHOP_EN
    logic                 cmd_bc4;
`endif
    logic                 wdata_req;
    logic [DW-1:0]        wdata;
    logic                 rdata_valid;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic [NBG-1:0][NBA-1:0]           chip_rd_o_wr;
    logic [NBG-1:0][NBA-1:0][DW-1:0]   chip_dqin;
    logic [NBG-1:0][NBA-1:0][DW-1:0]   chip_dqout = '0;
    logic [NBG-1:0][NBA-1:0][CHW-1:0]  chip_row;
    logic [NBG-1:0][NBA-1:0][COLW-1:0] chip_column;

    bank_burst_sequencer #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .COLWIDTH(COLW), .DEVICE_WIDTH(DW),
        .CHWIDTH(CHW), .BL(BL), .TRCD(TRCD), .TRP(TRP), .CHIP_RL(RL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr),
        .cmd_bg(cmd_bg),
        .cmd_ba(cmd_ba),
        .cmd_row(cmd_row),
        .cmd_col(cmd_col),
`ifdef BURST_CHOP_EN
        .cmd_bc4(cmd_bc4),
`endif
        .wdata_req(wdata_req),
        .wdata(wdata),
        .rdata_valid(rdata_valid),
        .rdata(rdata),
        .busy(busy),
        .chip_rd_o_wr(chip_rd_o_wr),
        .chip_dqin(chip_dqin),
        .chip_dqout(chip_dqout),
        .chip_row(chip_row),
        .chip_column(chip_column)
    );

    function automatic int mkey(int g, int b, int r, int c);
        return ((g * NBA + b) * (1 << CHW) + r) * (1 << COLW) + c;
    endfunction

    // Chip model: one-cycle read latency, writes land at the clock edge.
    logic [DW-1:0] chip_mem [int];
    always @(posedge clk) begin
        for (int g = 0; g < NBG; g++) begin
            for (int b = 0; b < NBA; b++) begin
                int key;
                key = mkey(g, b, int'(chip_row[g][b]), int'(chip_column[g][b]));
                chip_dqout[g][b] <= chip_mem.exists(key) ? chip_mem[key] : '0;
                if (chip_rd_o_wr[g][b]) chip_mem[key] = chip_dqin[g][b];
            end
        end
    end

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: one in-flight command described by its accept cycle.
    bit            act = 1'b0;
    bit            accepted = 1'b0;
    int            a_cyc = 0;
    int            dut_a_cyc = 0;
    bit            m_wr;
    int            m_bg, m_ba, m_row, m_col, m_n;
    logic [DW-1:0] wq [$];
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rbeat_t;
    rbeat_t        rq [$];
    logic [DW-1:0] ref_mem [int];

    bit d_rst_n = 1'b0;
    bit d_valid = 1'b0;
    bit d_wr = 1'b0;
    bit d_bc4 = 1'b0;
    int d_bg = 0, d_ba = 0, d_row = 0, d_col = 0;

    function automatic int exp_col(int col, int n, int k);
        return col - (col % n) + ((col % n) + k) % n;
    endfunction

    task automatic step();
        int off, k, c, key;
        logic [NBG-1:0][NBA-1:0]           e_rdwr;
        logic [NBG-1:0][NBA-1:0][DW-1:0]   e_dqin;
        logic [NBG-1:0][NBA-1:0][CHW-1:0]  e_row;
        logic [NBG-1:0][NBA-1:0][COLW-1:0] e_col;
        bit e_req, e_ready, e_rv;
        @(negedge clk);
        cyc++;
        rst_n     = d_rst_n;
        cmd_valid = d_valid;
        cmd_wr    = d_wr;
        cmd_bg    = BGW'(d_bg);
        cmd_ba    = BAW'(d_ba);
        cmd_row   = CHW'(d_row);
        cmd_col   = COLW'(d_col);
`ifdef BURST_CHOP_EN
        cmd_bc4   = d_bc4;
`endif
        if (!rst_n) begin
            act = 1'b0;
            rq.delete();
        end
        e_rdwr = '0; e_dqin = '0; e_row = '0; e_col = '0; e_req = 1'b0;
        wdata = DW'($urandom);
        off = cyc - a_cyc;
        if (act) begin
            if (off >= 1 && off <= TRCD) begin
                e_row[m_bg][m_ba] = CHW'(m_row);
            end else if (off > TRCD && off <= TRCD + m_n) begin
                k = off - TRCD - 1;
                c = exp_col(m_col, m_n, k);
                key = mkey(m_bg, m_ba, m_row, c);
                e_row[m_bg][m_ba] = CHW'(m_row);
                e_col[m_bg][m_ba] = COLW'(c);
                if (m_wr) begin
                    wdata = wq[k];
                    e_rdwr[m_bg][m_ba] = 1'b1;
                    e_dqin[m_bg][m_ba] = wdata;
                    e_req = 1'b1;
                    ref_mem[key] = wdata;
                end else begin
                    rq.push_back('{cyc + RL, ref_mem.exists(key) ? ref_mem[key] : DW'(0)});
                end
            end
        end
        e_ready = !act || (off > TRCD + m_n + TRP);
        #1;
        chk("cmd_ready", 256'(cmd_ready), 256'(e_ready));
        chk("busy", 256'(busy), 256'(!e_ready));
        chk("wdata_req", 256'(wdata_req), 256'(e_req));
        chk("rd_o_wr", 256'(chip_rd_o_wr), 256'(e_rdwr));
        chk("row", 256'(chip_row), 256'(e_row));
        chk("column", 256'(chip_column), 256'(e_col));
        chk("dqin", 256'(chip_dqin), 256'(e_dqin));
        e_rv = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rdata_valid", 256'(rdata_valid), 256'(e_rv));
        if (e_rv) begin
            chk("rdata", 256'(rdata), 256'(rq[0].data));
            void'(rq.pop_front());
        end
        if (cmd_valid && cmd_ready) dut_a_cyc = cyc;
        accepted = 1'b0;
        if (rst_n && cmd_valid && e_ready) begin
            act = 1'b1; accepted = 1'b1; a_cyc = cyc;
            m_wr = d_wr; m_bg = d_bg; m_ba = d_ba; m_row = d_row; m_col = d_col;
            m_n = d_bc4 ? BL / 2 : BL;
            wq.delete();
            for (int i = 0; i < m_n; i++) wq.push_back(DW'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input bit wr, input int bg, input int ba, input int row,
                         input int col, input bit bc4);
        d_wr = wr; d_bg = bg; d_ba = ba; d_row = row; d_col = col; d_bc4 = bc4;
        d_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            step();
            if (accepted) break;
        end
        chk("accept_timeout", 256'(accepted), 256'(1));
        d_valid = 1'b0;
    endtask

    // Asserts reset between edges and checks the outputs react without a clock.
    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 256'(cmd_ready), 256'(1));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_wdata_req", 256'(wdata_req), 256'(0));
        chk("rst_rdata_valid", 256'(rdata_valid), 256'(0));
        chk("rst_rdata", 256'(rdata), 256'(0));
        chk("rst_rd_o_wr", 256'(chip_rd_o_wr), 256'(0));
        chk("rst_row", 256'(chip_row), 256'(0));
        chk("rst_column", 256'(chip_column), 256'(0));
        chk("rst_dqin", 256'(chip_dqin), 256'(0));
        act = 1'b0;
        rq.delete();
        d_rst_n = 1'b1;
        d_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t1;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_bg = '0; cmd_ba = '0;
        cmd_row = '0; cmd_col = '0; wdata = '0;
`ifdef BURST_CHOP_EN
        cmd_bc4 = 1'b0;
`endif
        idle(2);
        d_rst_n = 1'b1;
        idle(3);

        issue(1'b1, 1, 1, 1, 0, 1'b0);
        idle(12);
        issue(1'b0, 1, 1, 1, 0, 1'b0);
        idle(14);

        issue(1'b1, 2, 3, 4, 0, 1'b0);
        issue(1'b0, 2, 3, 4, 6, 1'b0);
        issue(1'b1, 0, 2, 3, 'h3F8, 1'b0);
        issue(1'b0, 0, 2, 3, 'h3FE, 1'b0);
        idle(14);

        issue(1'b1, 3, 0, 2, 9, 1'b0);
        t1 = dut_a_cyc;
        issue(1'b0, 3, 0, 2, 9, 1'b0);
        chk("turnaround", 256'(dut_a_cyc - t1), 256'(TRCD + BL + TRP + 1));
        idle(14);

        issue(1'b1, 1, 2, 0, 0, 1'b0);
        step();
        reset_mid();
        idle(3);

        issue(1'b0, 1, 1, 1, 0, 1'b0);
        idle(TRCD + 3);
        reset_mid();
        idle(6);

`ifdef BURST_CHOP_EN
        issue(1'b1, 2, 1, 1, 5, 1'b1);
        t1 = dut_a_cyc;
        issue(1'b0, 2, 1, 1, 5, 1'b1);
        chk("chop_turnaround", 256'(dut_a_cyc - t1), 256'(TRCD + BL / 2 + TRP + 1));
        idle(12);
`endif

        for (int i = 0; i < 40; i++) begin
            bit rb;
`ifdef BURST_CHOP_EN
            rb = 1'($urandom_range(0, 1));
`else
            rb = 1'b0;
`endif
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, NBG - 1)),
                  int'($urandom_range(0, NBA - 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 31)), rb);
            idle(int'($urandom_range(0, 3)));
        end
        idle(16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
